// File: rtl/core_clock_gate_ctrl.sv
// Idle-detect / sleep FSM driving the core clock-gate enable; runs on the free-running clock.
// Optional gated-cycle statistics counter enabled by defining CLK_GATE_STATS_EN.
module core_clock_gate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        sleep_req_i,
    input  logic        busy_i,
    input  logic        wake_req_i,
    output logic        clk_en_o,
    output logic        sleep_ack_o,
    output logic        wake_ack_o,
    input  logic        stats_clr_i,
    output logic [31:0] gated_cycles_o
);

    localparam int MAX_CYC = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] IDLE_T   = CNT_W'(IDLE_CYCLES);
    localparam logic [CNT_W-1:0] WAKE_T   = CNT_W'(WAKE_CYCLES);

    typedef enum logic [1:0] {
        ACTIVE   = 2'd0,
        IDLE_CNT = 2'd1,
        GATED    = 2'd2,
        WAKING   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_en_q;
    logic             sleep_ack_q;
    logic             wake_ack_q;

    logic idle_ok;
    assign idle_ok = sleep_req_i & ~busy_i & ~wake_req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACTIVE: begin
                if (idle_ok) begin
                    state_d = IDLE_CNT;
                    cnt_d   = CNT_ONE;
                end
            end
            IDLE_CNT: begin
                // Abort is checked before the terminal count so a late wake never gates.
                if (!idle_ok) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_ZERO;
                end else if (cnt_q == IDLE_T) begin
                    state_d = GATED;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            GATED: begin
                if (!idle_ok) begin
                    state_d = WAKING;
                    cnt_d   = CNT_ONE;
                end
            end
            WAKING: begin
                if (cnt_q == WAKE_T) begin
                    state_d = ACTIVE;
                    cnt_d   = CNT_ZERO;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ACTIVE;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change exactly on the transition edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ACTIVE;
            cnt_q       <= CNT_ZERO;
            clk_en_q    <= 1'b1;
            sleep_ack_q <= 1'b0;
            wake_ack_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            clk_en_q    <= (state_d != GATED);
            sleep_ack_q <= (state_d == GATED);
            wake_ack_q  <= (state_q == WAKING) && (state_d == ACTIVE);
        end
    end

    assign clk_en_o    = clk_en_q;
    assign sleep_ack_o = sleep_ack_q;
    assign wake_ack_o  = wake_ack_q;

`ifdef CLK_GATE_STATS_EN
    logic [31:0] gated_cycles_q, gated_cycles_d;

    always_comb begin
        gated_cycles_d = gated_cycles_q;
        if (stats_clr_i) begin
            gated_cycles_d = 32'h0;
        end else if (!clk_en_q && (gated_cycles_q != 32'hFFFF_FFFF)) begin
            gated_cycles_d = gated_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_cycles_q <= 32'h0;
        end else begin
            gated_cycles_q <= gated_cycles_d;
        end
    end

    assign gated_cycles_o = gated_cycles_q;
`else
    logic unused_stats_clr;
    assign unused_stats_clr = stats_clr_i;
    assign gated_cycles_o   = 32'h0;
`endif

endmodule

// File: tb/tb_core_clock_gate_ctrl.sv
// Randomized bench for core_clock_gate_ctrl against a cycle-timestamp reference model.
module tb_core_clock_gate_ctrl;

    localparam int IDLE_CYCLES = 4;
    localparam int WAKE_CYCLES = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        sleep_req_i;
    logic        busy_i;
    logic        wake_req_i;
    logic        clk_en_o;
    logic        sleep_ack_o;
    logic        wake_ack_o;
    logic        stats_clr_i;
    logic [31:0] gated_cycles_o;

    core_clock_gate_ctrl #(
        .IDLE_CYCLES(IDLE_CYCLES),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sleep_req_i   (sleep_req_i),
        .busy_i        (busy_i),
        .wake_req_i    (wake_req_i),
        .clk_en_o      (clk_en_o),
        .sleep_ack_o   (sleep_ack_o),
        .wake_ack_o    (wake_ack_o),
        .stats_clr_i   (stats_clr_i),
        .gated_cycles_o(gated_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Reference model: counts consecutive qualifying samples and timestamps the wake start.
    int          cyc        = 0;
    int          idle_run   = 0;
    bit          m_gated    = 0;
    bit          m_waking   = 0;
    int          wake_start = 0;
    bit          m_ack      = 0;
    logic [31:0] m_stat     = 0;

`ifdef CLK_GATE_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input bit s, input bit b, input bit w, input bit c, input bit r);
        cyc++;
        if (r) begin
            idle_run = 0; m_gated = 0; m_waking = 0; m_ack = 0; m_stat = 0;
            return;
        end
        if (c) m_stat = 0;
        else if (m_gated && m_stat != 32'hFFFF_FFFF) m_stat = m_stat + 1;
        m_ack = 0;
        if (m_gated) begin
            if (w || b || !s) begin
                m_gated = 0; m_waking = 1; wake_start = cyc;
            end
        end else if (m_waking) begin
            if (cyc == wake_start + WAKE_CYCLES) begin
                m_waking = 0; m_ack = 1; idle_run = 0;
            end
        end else if (s && !b && !w) begin
            idle_run++;
            if (idle_run == IDLE_CYCLES + 1) begin
                m_gated = 1; idle_run = 0;
            end
        end else begin
            idle_run = 0;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".clk_en"},    {31'b0, clk_en_o},    {31'b0, !m_gated});
        check({tag, ".sleep_ack"}, {31'b0, sleep_ack_o}, {31'b0, m_gated});
        check({tag, ".wake_ack"},  {31'b0, wake_ack_o},  {31'b0, m_ack});
        check({tag, ".gated_cnt"}, gated_cycles_o, STATS_ON ? m_stat : 32'h0);
    endtask

    task automatic step(input string tag, input bit s, input bit b, input bit w,
                        input bit c, input bit r);
        sleep_req_i = s; busy_i = b; wake_req_i = w; stats_clr_i = c; rst_i = r;
        @(posedge clk_i);
        model_edge(s, b, w, c, r);
        #1;
        check_all(tag);
    endtask

    int wake_acks;

    initial begin
        sleep_req_i = 0; busy_i = 0; wake_req_i = 0; stats_clr_i = 0; rst_i = 1;
        #1;
        step("reset", 0, 0, 0, 0, 1);
        step("reset", 0, 0, 0, 0, 1);
        step("post_reset", 0, 0, 0, 0, 0);
        check("reset_clk_en_const", {31'b0, clk_en_o}, 32'd1);

        // Sleep entry: gated after IDLE_CYCLES+1 qualifying edges, held while idle.
        for (int i = 0; i < IDLE_CYCLES + 1; i++) begin
            check("entry_not_gated_yet", {31'b0, clk_en_o}, 32'd1);
            step("entry", 1, 0, 0, 0, 0);
        end
        check("entry_gated_const", {31'b0, clk_en_o}, 32'd0);
        for (int i = 0; i < 10; i++) step("hold", 1, 0, 0, 0, 0);
        check("stats_10", gated_cycles_o, STATS_ON ? 32'd10 : 32'd0);
        step("stats_clr", 1, 0, 0, 1, 0);
        check("stats_clr_zero", gated_cycles_o, 32'd0);
        for (int i = 0; i < 3; i++) step("stats_resume", 1, 0, 0, 0, 0);

        // Wake for one cycle, then count acks across the wake sequence.
        step("wake_req", 1, 0, 1, 0, 0);
        check("wake_clk_en_const", {31'b0, clk_en_o}, 32'd1);
        wake_acks = 0;
        for (int i = 0; i < 4; i++) begin
            step("waking", 0, 0, 0, 0, 0);
            wake_acks += int'(wake_ack_o);
        end
        check("wake_ack_once", wake_acks, 32'd1);

        // Abort at the 3rd idle sample, then a fresh full window is needed.
        for (int i = 0; i < 3; i++) step("abort_pre", 1, 0, 0, 0, 0);
        step("abort", 1, 1, 0, 0, 0);
        for (int i = 0; i < IDLE_CYCLES; i++) step("reentry", 1, 0, 0, 0, 0);
        check("reentry_not_yet", {31'b0, clk_en_o}, 32'd1);
        step("reentry_gate", 1, 0, 0, 0, 0);
        check("reentry_gated", {31'b0, sleep_ack_o}, 32'd1);
        step("exit", 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step("exit_wake", 0, 0, 0, 0, 0);

        // Wake request on the terminal idle sample: no gating, no ack.
        for (int i = 0; i < IDLE_CYCLES; i++) step("simul_pre", 1, 0, 0, 0, 0);
        step("simul", 1, 0, 1, 0, 0);
        check("simul_no_gate", {31'b0, clk_en_o}, 32'd1);
        step("simul_post", 0, 0, 0, 0, 0);
        check("simul_no_ack", {31'b0, wake_ack_o}, 32'd0);

        // Reset while gated returns straight to the active state.
        for (int i = 0; i < IDLE_CYCLES + 2; i++) step("rst_gate_pre", 1, 0, 0, 0, 0);
        step("rst_from_gated", 1, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            step("rand",
                 ($urandom % 8) != 0,
                 ($urandom % 7) == 0,
                 ($urandom % 10) == 0,
                 ($urandom % 23) == 0,
                 ($urandom % 301) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
